sin_ram_ctrl: RTL and testbench
===============================

# sin_ram_ctrl

Sequencing controller for the mixer's sine lookup RAM (simple dual-port, single clock, 2-cycle registered read latency). It fills the table from a ready/valid load stream, then drives the read port from a phase accumulator to produce a continuous sine sample stream for the mixer. It also tracks the RAM read latency so every output sample carries an aligned valid flag. It sits between the configuration/loader logic and the sine RAM instance, and owns all of the RAM's write and read control signals.

## Interface
Parameters:
- RAM_EXP, 5, log2 of table depth; RAM_DEPTH = 2**RAM_EXP
- RAM_WIDTH, 8, sample width (signed)
- PHASE_W, 16, phase accumulator width; must be >= RAM_EXP

Ports (direction, width, meaning):
- clk, in, 1, single clock, rising edge
- i_rst, in, 1, synchronous, active-high reset
- i_load_start, in, 1, request a full table load (sampled in IDLE)
- i_load_valid, in, 1, load data valid
- i_load_data, in, RAM_WIDTH, table entry
- o_load_ready, out, 1, high throughout LOAD
- o_load_done, out, 1, one-cycle pulse after the last table write
- i_run_enb, in, 1, run sample generation while high
- i_phase_inc, in, PHASE_W, phase step; captured on IDLE->RUN
- o_addr_w, out, RAM_EXP, RAM write address
- o_data_ram, out, RAM_WIDTH, RAM write data
- o_write_enb, out, 1, RAM write enable
- o_addr_r, out, RAM_EXP, RAM read address
- o_read_enb, out, 1, RAM read enable
- i_ram_data, in, RAM_WIDTH, RAM read data (signed)
- o_sample, out, RAM_WIDTH, signed sample (pass-through of i_ram_data)
- o_sample_valid, out, 1, o_sample is valid this cycle
- o_state, out, 2, current state: IDLE=0, LOAD=1, RUN=2, FLUSH=3

## Operation
- **IDLE**
  - If i_load_start is high, go to LOAD; load has priority when both requests are high.
  - Else if i_run_enb is high, go to RUN: latch i_phase_inc into inc_reg and clear acc to 0.
- **LOAD**
  - o_load_ready = 1.
  - o_write_enb = i_load_valid (combinational). o_addr_w = wcnt. o_data_ram = i_load_data.
  - wcnt increments on each accepted write and holds on cycles with i_load_valid low.
  - After the write at wcnt = RAM_DEPTH-1: wcnt wraps to 0, the block goes to IDLE, and o_load_done pulses in the next cycle.
  - i_load_start and i_run_enb are ignored during LOAD.
- **RUN**
  - o_read_enb = 1. o_addr_r = acc[PHASE_W-1 -: RAM_EXP].
  - Every cycle: acc <= acc + inc_reg, modulo 2**PHASE_W (the wrap is silent).
  - If i_run_enb is low, go to FLUSH. The read issued in that cycle still counts, so the number of reads equals the number of RUN cycles.
- **FLUSH**
  - o_read_enb = 0.
  - Stays exactly 2 cycles, counted by a 1-bit counter, then goes to IDLE. No new load or run starts until the pipeline has drained.
- **Valid pipeline**
  - rd_v1 <= o_read_enb; rd_v2 <= rd_v1; o_sample_valid = rd_v2.
  - o_sample = i_ram_data, unregistered.
- While not in LOAD: o_write_enb = 0, o_addr_w = wcnt, o_data_ram = i_load_data.
- While not in RUN: o_addr_r holds the acc-derived value, and acc keeps its value.
- **Reset:** state = IDLE, wcnt = 0, acc = 0, inc_reg = 0, rd_v1 = rd_v2 = 0, o_load_done = 0, all enables 0. Reset mid-LOAD or mid-RUN aborts immediately, and o_sample_valid is 0 from the cycle after the reset edge. RAM contents are not affected.

## Timing
- **Read latency:** a read issued in cycle n gives o_sample_valid = 1 in cycle n+2, with the matching data.
- **Load:** a write is committed at the edge ending the cycle in which o_write_enb = 1. o_load_done is high in the cycle following the final write, while o_state = IDLE.
- **Load throughput:** one entry per cycle; RAM_DEPTH back-to-back valids take RAM_DEPTH cycles.
- **RUN entry:** the first read (addr 0) is issued in the first RUN cycle, one cycle after i_run_enb is seen in IDLE.
- **Last sample:** the final valid sample appears in the second FLUSH cycle.
- **Back-to-back runs:** a RUN -> FLUSH -> IDLE -> RUN cycle gives a 3-cycle read gap. acc restarts at 0 and a new inc_reg is captured.

## Test plan
- **Full load:** reset, then i_load_start with continuous valid and data 0x00..0x1F.
  - Expect 32 writes at addr 0..31 with matching data.
  - o_load_done pulses once, one cycle after the addr-31 write; o_state = 0 in that cycle.
- **Gapped load:** i_load_valid toggling 1,0,1,0...
  - Expect 32 writes at contiguous addresses 0..31 over 63 cycles, no write on gap cycles, a single o_load_done pulse, and o_load_ready constant 1 during LOAD.
- **Unit-step run:** with a sin_ram model loaded with 0x00..0x1F, run with inc = 0x0800.
  - o_addr_r = 0,1,...,31,0,1 (wrap).
  - o_sample_valid first high 2 cycles after the first read.
  - o_sample = 0x00,0x01,... in order.
- **Fractional step:** inc = 0x0C00.
  - o_addr_r = 0,1,3,4,6,7,9 (acc 0x0000,0x0C00,0x1800,0x2400,...).
- **Stop and drain:** drop i_run_enb after exactly 10 RUN cycles.
  - Expect exactly 10 valid samples, 2 FLUSH cycles, then IDLE.
  - Then assert i_load_start and i_run_enb together in IDLE: the block must enter LOAD.
- **Reset mid-run:** assert i_rst during RUN.
  - Next cycle: o_state = 0, o_read_enb = 0, o_sample_valid = 0.
  - A new run with inc = 0x0800 restarts at addr 0.

Source files
------------

// File: rtl/sin_ram_ctrl.sv
// Sine lookup RAM sequencer: fills the table from a ready/valid stream, then
// sweeps the read port with a phase accumulator and tags samples with a valid flag.
module sin_ram_ctrl #(
    parameter int RAM_EXP   = 5,
    parameter int RAM_WIDTH = 8,
    parameter int PHASE_W   = 16
) (
    input  logic                 clk,
    input  logic                 i_rst,
    input  logic                 i_load_start,
    input  logic                 i_load_valid,
    input  logic [RAM_WIDTH-1:0] i_load_data,
    output logic                 o_load_ready,
    output logic                 o_load_done,
    input  logic                 i_run_enb,
    input  logic [PHASE_W-1:0]   i_phase_inc,
    output logic [RAM_EXP-1:0]   o_addr_w,
    output logic [RAM_WIDTH-1:0] o_data_ram,
    output logic                 o_write_enb,
    output logic [RAM_EXP-1:0]   o_addr_r,
    output logic                 o_read_enb,
    input  logic [RAM_WIDTH-1:0] i_ram_data,
    output logic [RAM_WIDTH-1:0] o_sample,
    output logic                 o_sample_valid,
    output logic [1:0]           o_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    logic [1:0]           r_state;
    logic [RAM_EXP-1:0]   r_wcnt;
    logic [PHASE_W-1:0]   r_acc;
    logic [PHASE_W-1:0]   r_inc;
    logic                 r_flush_cnt;
    logic                 r_rd_v1;
    logic                 r_rd_v2;
    logic                 r_load_done;

    logic                 w_in_load;
    logic                 w_in_run;
    logic                 w_wr;

    assign w_in_load = (r_state == S_LOAD);
    assign w_in_run  = (r_state == S_RUN);
    assign w_wr      = w_in_load & i_load_valid;

    assign o_load_ready   = w_in_load;
    assign o_load_done    = r_load_done;
    assign o_write_enb    = w_wr;
    assign o_addr_w       = r_wcnt;
    assign o_data_ram     = i_load_data;
    assign o_read_enb     = w_in_run;
    assign o_addr_r       = r_acc[PHASE_W-1 -: RAM_EXP];
    assign o_sample       = i_ram_data;
    assign o_sample_valid = r_rd_v2;
    assign o_state        = r_state;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_wcnt      <= '0;
            r_acc       <= '0;
            r_inc       <= '0;
            r_flush_cnt <= 1'b0;
            r_rd_v1     <= 1'b0;
            r_rd_v2     <= 1'b0;
            r_load_done <= 1'b0;
        end else begin
            r_load_done <= 1'b0;
            // Two-stage valid shadow matches the RAM's registered read latency
            r_rd_v1     <= w_in_run;
            r_rd_v2     <= r_rd_v1;
            case (r_state)
                S_IDLE: begin
                    if (i_load_start) begin
                        r_state <= S_LOAD;
                    end else if (i_run_enb) begin
                        r_state <= S_RUN;
                        r_inc   <= i_phase_inc;
                        r_acc   <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_wr) begin
                        r_wcnt <= r_wcnt + 1'b1;
                        if (&r_wcnt) begin
                            r_state     <= S_IDLE;
                            r_load_done <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    r_acc <= r_acc + r_inc;
                    if (!i_run_enb) begin
                        r_state     <= S_FLUSH;
                        r_flush_cnt <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    // Two drain cycles let the last issued read reach the output
                    r_flush_cnt <= 1'b1;
                    if (r_flush_cnt) begin
                        r_state     <= S_IDLE;
                        r_flush_cnt <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sin_ram_ctrl.sv
// Self-checking bench for sin_ram_ctrl with a behavioural sine RAM and
// a phase-arithmetic reference for addresses and samples.
module tb_sin_ram_ctrl;

    localparam int RAM_EXP   = 5;
    localparam int RAM_WIDTH = 8;
    localparam int PHASE_W   = 16;
    localparam int DEPTH     = 32;

    logic                 clk = 1'b0;
    logic                 i_rst;
    logic                 i_load_start;
    logic                 i_load_valid;
    logic [RAM_WIDTH-1:0] i_load_data;
    logic                 o_load_ready;
    logic                 o_load_done;
    logic                 i_run_enb;
    logic [PHASE_W-1:0]   i_phase_inc;
    logic [RAM_EXP-1:0]   o_addr_w;
    logic [RAM_WIDTH-1:0] o_data_ram;
    logic                 o_write_enb;
    logic [RAM_EXP-1:0]   o_addr_r;
    logic                 o_read_enb;
    logic [RAM_WIDTH-1:0] i_ram_data;
    logic [RAM_WIDTH-1:0] o_sample;
    logic                 o_sample_valid;
    logic [1:0]           o_state;

    always #5 clk = ~clk;

    sin_ram_ctrl #(.RAM_EXP(RAM_EXP), .RAM_WIDTH(RAM_WIDTH), .PHASE_W(PHASE_W)) dut (
        .clk(clk), .i_rst(i_rst),
        .i_load_start(i_load_start), .i_load_valid(i_load_valid), .i_load_data(i_load_data),
        .o_load_ready(o_load_ready), .o_load_done(o_load_done),
        .i_run_enb(i_run_enb), .i_phase_inc(i_phase_inc),
        .o_addr_w(o_addr_w), .o_data_ram(o_data_ram), .o_write_enb(o_write_enb),
        .o_addr_r(o_addr_r), .o_read_enb(o_read_enb), .i_ram_data(i_ram_data),
        .o_sample(o_sample), .o_sample_valid(o_sample_valid), .o_state(o_state)
    );

    // Sine RAM: simple dual port, two-cycle registered read
    logic [RAM_WIDTH-1:0] mem [0:DEPTH-1];
    logic [RAM_WIDTH-1:0] rd1;
    logic [RAM_WIDTH-1:0] ram_q;
    always @(posedge clk) begin
        if (o_write_enb) mem[o_addr_w] <= o_data_ram;
        if (o_read_enb) rd1 <= mem[o_addr_r];
        ram_q <= rd1;
    end
    assign i_ram_data = ram_q;

    int n_vec = 0;
    int n_err = 0;
    logic [RAM_WIDTH-1:0] tbl [0:DEPTH-1];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) cyc();
        #1;
        n_vec++;
        if (o_state !== 2'd0 || o_read_enb !== 1'b0 || o_write_enb !== 1'b0 ||
            o_load_ready !== 1'b0 || o_load_done !== 1'b0 || o_sample_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset: state=%0d rd=%b wr=%b rdy=%b done=%b vld=%b want 0,0,0,0,0,0",
                     o_state, o_read_enb, o_write_enb, o_load_ready, o_load_done, o_sample_valid);
        end
        i_rst = 1'b0;
        cyc();
    endtask

    // mode 0: continuous valid, 1: toggling valid, 2: random valid
    task automatic do_load(input int mode, input bit with_run, input string name);
        int  writes;
        int  cycles;
        bit  v;
        writes = 0;
        cycles = 0;
        i_load_start = 1'b1;
        i_run_enb    = with_run;
        i_load_valid = 1'b0;
        #1;
        n_vec++;
        if (o_state !== 2'd0) begin
            n_err++;
            $display("FAIL %s idle_before: state=%0d want 0", name, o_state);
        end
        cyc();
        while (writes < DEPTH && cycles < 400) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cycles % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            i_load_valid = v;
            i_load_data  = tbl[writes];
            i_load_start = 1'($urandom_range(0, 1));
            i_run_enb    = 1'($urandom_range(0, 1));
            #1;
            n_vec++;
            if (o_state !== 2'd1 || o_load_ready !== 1'b1 || o_load_done !== 1'b0) begin
                n_err++;
                $display("FAIL %s in_load: state=%0d rdy=%b done=%b want 1,1,0 (cycle %0d)",
                         name, o_state, o_load_ready, o_load_done, cycles);
            end
            n_vec++;
            if (o_write_enb !== v) begin
                n_err++;
                $display("FAIL %s write_enb: got %b want %b (cycle %0d)", name, o_write_enb, v, cycles);
            end
            if (v) begin
                n_vec++;
                if (o_addr_w !== 5'(writes) || o_data_ram !== tbl[writes]) begin
                    n_err++;
                    $display("FAIL %s write: addr=%0d data=%h want addr=%0d data=%h",
                             name, o_addr_w, o_data_ram, writes, tbl[writes]);
                end
                writes++;
            end
            cycles++;
            cyc();
        end
        i_load_valid = 1'b0;
        i_load_start = 1'b0;
        i_run_enb    = 1'b0;
        n_vec++;
        if (writes != DEPTH) begin
            n_err++;
            $display("FAIL %s timeout: writes=%0d want %0d", name, writes, DEPTH);
        end
        if (mode < 2) begin
            n_vec++;
            if (cycles != ((mode == 0) ? DEPTH : 2 * DEPTH - 1)) begin
                n_err++;
                $display("FAIL %s load_cycles: got %0d want %0d", name, cycles,
                         (mode == 0) ? DEPTH : 2 * DEPTH - 1);
            end
        end
        #1;
        n_vec++;
        if (o_state !== 2'd0 || o_load_done !== 1'b1 || o_load_ready !== 1'b0 || o_write_enb !== 1'b0) begin
            n_err++;
            $display("FAIL %s done_pulse: state=%0d done=%b rdy=%b wr=%b want 0,1,0,0",
                     name, o_state, o_load_done, o_load_ready, o_write_enb);
        end
        cyc();
        #1;
        n_vec++;
        if (o_load_done !== 1'b0) begin
            n_err++;
            $display("FAIL %s done_single: got %b want 0", name, o_load_done);
        end
        cyc();
    endtask

    task automatic do_run(input logic [PHASE_W-1:0] inc, input int nrun, input string name);
        logic [RAM_WIDTH-1:0] expq[$];
        int          nvalid;
        int unsigned ph;
        int          exp_addr;
        bit          exp_valid;
        nvalid = 0;
        i_run_enb   = 1'b1;
        i_phase_inc = inc;
        #1;
        n_vec++;
        if (o_state !== 2'd0 || o_sample_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s idle_before: state=%0d vld=%b want 0,0", name, o_state, o_sample_valid);
        end
        cyc();
        i_phase_inc = 16'($urandom);
        for (int k = 0; k < nrun + 2; k++) begin
            i_run_enb = (k < nrun - 1);
            #1;
            if (k < nrun) begin
                ph       = (k * int'(inc)) % 65536;
                exp_addr = int'(ph >> 11);
                expq.push_back(tbl[exp_addr]);
                n_vec++;
                if (o_state !== 2'd2 || o_read_enb !== 1'b1 || o_addr_r !== 5'(exp_addr)) begin
                    n_err++;
                    $display("FAIL %s read%0d: state=%0d rd=%b addr=%0d want 2,1,%0d",
                             name, k, o_state, o_read_enb, o_addr_r, exp_addr);
                end
            end else begin
                n_vec++;
                if (o_state !== 2'd3 || o_read_enb !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s flush%0d: state=%0d rd=%b want 3,0", name, k - nrun, o_state, o_read_enb);
                end
            end
            exp_valid = (k >= 2);
            n_vec++;
            if (o_sample_valid !== exp_valid) begin
                n_err++;
                $display("FAIL %s valid%0d: got %b want %b", name, k, o_sample_valid, exp_valid);
            end
            if (o_sample_valid === 1'b1) nvalid++;
            if (exp_valid) begin
                n_vec++;
                if (o_sample !== expq[k - 2]) begin
                    n_err++;
                    $display("FAIL %s sample%0d: got %h want %h", name, k - 2, o_sample, expq[k - 2]);
                end
            end
            cyc();
        end
        n_vec++;
        if (o_state !== 2'd0 || o_sample_valid !== 1'b0 || nvalid != nrun) begin
            n_err++;
            $display("FAIL %s drained: state=%0d vld=%b samples=%0d want 0,0,%0d",
                     name, o_state, o_sample_valid, nvalid, nrun);
        end
    endtask

    task automatic test_full_load();
        for (int i = 0; i < DEPTH; i++) tbl[i] = 8'(i);
        do_load(0, 1'b0, "full_load");
    endtask

    task automatic test_unit_step();
        do_run(16'h0800, 40, "unit_step");
    endtask

    task automatic test_fractional();
        do_run(16'h0C00, 12, "frac_step");
    endtask

    task automatic test_stop_and_drain();
        do_run(16'h0800, 10, "stop_drain");
        for (int i = 0; i < DEPTH; i++) tbl[i] = 8'($urandom);
        do_load(1, 1'b1, "gapped_load");
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 4; r++) begin
            do_run(16'($urandom), int'($urandom_range(1, 40)), "b2b_run");
        end
    endtask

    task automatic test_random_load();
        for (int i = 0; i < DEPTH; i++) tbl[i] = 8'($urandom);
        do_load(2, 1'b0, "rand_load");
        do_run(16'($urandom), 25, "rand_run");
    endtask

    task automatic test_reset_mid_run();
        i_run_enb   = 1'b1;
        i_phase_inc = 16'h0C00;
        #1;
        cyc();
        repeat (5) begin
            #1;
            cyc();
        end
        i_rst     = 1'b1;
        i_run_enb = 1'b0;
        #1;
        cyc();
        i_rst = 1'b0;
        #1;
        n_vec++;
        if (o_state !== 2'd0 || o_read_enb !== 1'b0 || o_sample_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_run: state=%0d rd=%b vld=%b want 0,0,0",
                     o_state, o_read_enb, o_sample_valid);
        end
        cyc();
        do_run(16'h0800, 20, "post_reset_run");
    endtask

    initial begin
        i_rst        = 1'b1;
        i_load_start = 1'b0;
        i_load_valid = 1'b0;
        i_load_data  = '0;
        i_run_enb    = 1'b0;
        i_phase_inc  = '0;
        test_reset();
        test_full_load();
        test_unit_step();
        test_fractional();
        test_stop_and_drain();
        test_back_to_back();
        test_random_load();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
